// File: rtl/io_bus_ram_pkg.sv
// Shared encodings for the cpu16 I/O-bus RAM peripheral: FSM states, op codes, default widths.
package io_bus_ram_pkg;

  localparam int BUS_WIDTH_DEFAULT = 16;
  localparam int WAIT_CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/io_ram_core.sv
// Single-port synchronous RAM with a registered, read-enabled output port.
// Latency: write commits and read data appear at the edge where we/re is high; backpressure: none.
// Reset clears only the output register; the array keeps its contents.
module io_ram_core #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 10
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Output register holds the last read value between read completions.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  rdata <= '0;
    else if (re)  rdata <= mem[addr];
  end

endmodule

// File: rtl/io_bus_ram.sv
// RAM peripheral on the cpu16 I/O bus with address window, wait states, ready handshake and collision flag.
// Latency: ready and read data valid WAIT_STATES edges after the first edge that samples a selected strobe low.
// Backpressure: access holds in DONE until the bus releases the strobe; early release aborts without side effects.
module io_bus_ram
  import io_bus_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = BUS_WIDTH_DEFAULT,
  parameter int                    ADDR_WIDTH  = BUS_WIDTH_DEFAULT,
  parameter int                    DEPTH_LOG2  = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE        = '0,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] io_address,
  input  logic                  io_rd,
  input  logic                  io_wr,
  input  logic [DATA_WIDTH-1:0] io_data_in,
  output logic [DATA_WIDTH-1:0] io_data_out,
  output logic                  io_data_oe,
  output logic                  ready,
  output logic                  error
);

  localparam logic [WAIT_CNT_W-1:0] WS = WAIT_CNT_W'(WAIT_STATES);

  state_t                state, state_nxt;
  op_t                   op, op_nxt;
  logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;
  logic                  rd_q, wr_q;
  logic                  sel, collide, rd_fall, wr_fall, start, strobe_hi;
  logic                  enter_done, ram_we, ram_re;

  assign sel     = (io_address[ADDR_WIDTH-1:DEPTH_LOG2] == BASE[ADDR_WIDTH-1:DEPTH_LOG2]);
  assign collide = sel && !io_rd && !io_wr;

  // A start needs exactly one strobe low and that strobe freshly fallen.
  assign rd_fall = !io_rd && rd_q && io_wr;
  assign wr_fall = !io_wr && wr_q && io_rd;
  assign start   = (state == ST_IDLE) && sel && (rd_fall || wr_fall);

  assign strobe_hi = (op == OP_RD) ? io_rd : io_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      op    <= OP_RD;
      cnt   <= '0;
      rd_q  <= 1'b1;
      wr_q  <= 1'b1;
      error <= 1'b0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      cnt   <= cnt_nxt;
      rd_q  <= io_rd;
      wr_q  <= io_wr;
      if (collide) error <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          op_nxt    = rd_fall ? OP_RD : OP_WR;
          cnt_nxt   = WS;
          state_nxt = (WS == '0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A released strobe or a collision abandons the access before any side effect.
        if (strobe_hi || collide)         state_nxt = ST_IDLE;
        else if (cnt == WAIT_CNT_W'(1))   state_nxt = ST_DONE;
        else                              cnt_nxt   = cnt - WAIT_CNT_W'(1);
      end
      ST_DONE: begin
        if (strobe_hi || collide) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready      = (state == ST_DONE);
    io_data_oe = (state == ST_DONE) && (op == OP_RD) && !io_rd && sel;
  end

  assign enter_done = (state_nxt == ST_DONE) && (state != ST_DONE);
  assign ram_we     = enter_done && (op_nxt == OP_WR);
  assign ram_re     = enter_done && (op_nxt == OP_RD);

  io_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (DEPTH_LOG2)
  ) u_core (
    .clk    (clk),
    .arst_n (reset),
    .we     (ram_we),
    .re     (ram_re),
    .addr   (io_address[DEPTH_LOG2-1:0]),
    .wdata  (io_data_in),
    .rdata  (io_data_out)
  );

endmodule
